stopwatch_ctrl: RTL and testbench

Control block for the lab stopwatch. It owns the minutes/seconds time registers, sequences them through idle/run/pause/adjust states, and generates per-field blanking for the blink effect in adjust mode. It sits between the debounced board buttons/switches and the 4-digit seven-segment multiplexer. It feeds that multiplexer's binary `minutes`/`seconds` inputs, 0–59 each.

---
 rtl/stopwatch_ctrl.sv | 146 ++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// rtl/stopwatch_ctrl.sv - stopwatch time registers, run/pause/adjust sequencing, adjust-mode blink
//
// Ports:
//   clk        system clock, rising-edge
//   rst        asynchronous active-high reset
//   tick_1hz   one-cycle 1 Hz count enable (RUN)
//   tick_2hz   one-cycle 2 Hz enable (ADJUST step and blink phase)
//   btn_pause  debounced level, rising edge starts/pauses
//   btn_reset  debounced level, rising edge clears to 00:00 / IDLE
//   adj        adjust-mode switch level
//   sel        adjust field select, 0 = seconds, 1 = minutes
//   minutes    binary 0-59
//   seconds    binary 0-59
//   blank_min  blank minutes digits
//   blank_sec  blank seconds digits
//   running    high while in RUN

module stopwatch_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_1hz,
  input  logic       tick_2hz,
  input  logic       btn_pause,
  input  logic       btn_reset,
  input  logic       adj,
  input  logic       sel,
  output logic [7:0] minutes,
  output logic [7:0] seconds,
  output logic       blank_min,
  output logic       blank_sec,
  output logic       running
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSE  = 2'd2,
    ADJUST = 2'd3
  } state_t;

  localparam logic [7:0] FIELD_MAX = 8'd59;

  state_t     state, state_n;
  logic [7:0] min_n, sec_n;
  logic       phase, phase_n;
  logic       pause_prev, reset_prev;
  logic       sel_q;
  logic       pause_edge, reset_edge;

  assign pause_edge = btn_pause & ~pause_prev;
  assign reset_edge = btn_reset & ~reset_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      minutes    <= 8'd0;
      seconds    <= 8'd0;
      phase      <= 1'b0;
      pause_prev <= 1'b0;
      reset_prev <= 1'b0;
      sel_q      <= 1'b0;
    end else begin
      state      <= state_n;
      minutes    <= min_n;
      seconds    <= sec_n;
      phase      <= phase_n;
      pause_prev <= btn_pause;
      reset_prev <= btn_reset;
      sel_q      <= sel;
    end
  end

  always_comb begin
    state_n = state;
    min_n   = minutes;
    sec_n   = seconds;
    phase_n = phase;

    if (reset_edge) begin
      // Clear wins over everything in the same cycle, including a tick.
      state_n = IDLE;
      min_n   = 8'd0;
      sec_n   = 8'd0;
      phase_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (adj) begin
            state_n = ADJUST;
            phase_n = 1'b0;
          end else if (pause_edge) begin
            state_n = RUN;
          end
        end

        RUN: begin
          // Counting keys off the current state, so a tick on the exit cycle still counts.
          if (tick_1hz) begin
            if (seconds == FIELD_MAX) begin
              sec_n = 8'd0;
              min_n = (minutes == FIELD_MAX) ? 8'd0 : minutes + 8'd1;
            end else begin
              sec_n = seconds + 8'd1;
            end
          end
          if (adj) begin
            state_n = ADJUST;
            phase_n = 1'b0;
          end else if (pause_edge) begin
            state_n = PAUSE;
          end
        end

        PAUSE: begin
          if (adj) begin
            state_n = ADJUST;
            phase_n = 1'b0;
          end else if (pause_edge) begin
            state_n = RUN;
          end
        end

        ADJUST: begin
          // Selected field steps mod 60 with no carry into the other field.
          if (tick_2hz) begin
            phase_n = ~phase;
            if (sel)
              min_n = (minutes == FIELD_MAX) ? 8'd0 : minutes + 8'd1;
            else
              sec_n = (seconds == FIELD_MAX) ? 8'd0 : seconds + 8'd1;
          end
          if (!adj)
            state_n = PAUSE;
        end

        default: state_n = IDLE;
      endcase
    end
  end

  // Blanking uses the registered copy of sel so no input reaches an output combinationally.
  assign running   = (state == RUN);
  assign blank_sec = (state == ADJUST) & ~sel_q & phase;
  assign blank_min = (state == ADJUST) & sel_q & phase;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb/tb_stopwatch_ctrl.sv - table-driven and directed-sequence bench for stopwatch_ctrl

module tb_stopwatch_ctrl;

  logic       clk;
  logic       rst;
  logic       tick_1hz, tick_2hz, btn_pause, btn_reset, adj, sel;
  logic [7:0] minutes, seconds;
  logic       blank_min, blank_sec, running;

  int total;
  int bad;

  stopwatch_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .tick_1hz  (tick_1hz),
    .tick_2hz  (tick_2hz),
    .btn_pause (btn_pause),
    .btn_reset (btn_reset),
    .adj       (adj),
    .sel       (sel),
    .minutes   (minutes),
    .seconds   (seconds),
    .blank_min (blank_min),
    .blank_sec (blank_sec),
    .running   (running)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       rst, t1, t2, bp, br, adj, sel;
    logic [7:0] emin, esec;
    logic       erun, ebmin, ebsec;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r, t1, t2, bp, br, a, s,
                              input int em, es, input logic er, ebm, ebs);
    vec_t v;
    v.rst = r; v.t1 = t1; v.t2 = t2; v.bp = bp; v.br = br; v.adj = a; v.sel = s;
    v.emin = em[7:0]; v.esec = es[7:0];
    v.erun = er; v.ebmin = ebm; v.ebsec = ebs;
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input int em, es, input logic er, ebm, ebs);
    chk({name, ".min"},  int'(minutes),   em);
    chk({name, ".sec"},  int'(seconds),   es);
    chk({name, ".run"},  int'(running),   int'(er));
    chk({name, ".bmin"}, int'(blank_min), int'(ebm));
    chk({name, ".bsec"}, int'(blank_sec), int'(ebs));
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic cyc(input logic t1, t2, bp, br, a, s);
    tick_1hz = t1; tick_2hz = t2; btn_pause = bp; btn_reset = br; adj = a; sel = s;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    rst = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1;
    tick_1hz = 0; tick_2hz = 0; btn_pause = 0; btn_reset = 0; adj = 0; sel = 0;
    #1;
    chk_all("async_reset_initial", 0, 0, 0, 0, 0);

    //                r  t1 t2 bp br adj sel  min sec run bmin bsec
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0,   0,  0, 0, 0, 0)); // 0 reset
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0,  0, 0, 0, 0)); // 1 idle
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 0,   0,  0, 0, 0, 0)); // 2 tick ignored in idle
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 0,   0,  0, 1, 0, 0)); // 3 start
    vq.push_back(mk(0, 1, 0, 1, 0, 0, 0,   0,  1, 1, 0, 0)); // 4 held button, count
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 0,   0,  2, 1, 0, 0)); // 5
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 0,   0,  3, 1, 0, 0)); // 6
    vq.push_back(mk(0, 1, 0, 1, 0, 0, 0,   0,  4, 0, 0, 0)); // 7 pause with tick counted
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 0,   0,  4, 0, 0, 0)); // 8 held in pause
    vq.push_back(mk(0, 0, 1, 0, 0, 0, 0,   0,  4, 0, 0, 0)); // 9 2hz ignored in pause
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 0,   0,  4, 0, 0, 0)); // 10 enter adjust
    vq.push_back(mk(0, 0, 1, 0, 0, 1, 0,   0,  5, 0, 0, 1)); // 11 seconds step, blink
    vq.push_back(mk(0, 1, 0, 0, 0, 1, 0,   0,  5, 0, 0, 1)); // 12 1hz ignored
    vq.push_back(mk(0, 0, 0, 1, 0, 1, 0,   0,  5, 0, 0, 1)); // 13 pause ignored
    vq.push_back(mk(0, 0, 1, 0, 0, 1, 1,   1,  5, 0, 0, 0)); // 14 minutes step
    vq.push_back(mk(0, 0, 1, 0, 0, 1, 1,   2,  5, 0, 1, 0)); // 15
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1,   2,  5, 0, 0, 0)); // 16 leave to pause
    vq.push_back(mk(0, 0, 0, 1, 0, 0, 0,   2,  5, 1, 0, 0)); // 17 resume
    vq.push_back(mk(0, 1, 0, 0, 0, 0, 0,   2,  6, 1, 0, 0)); // 18
    vq.push_back(mk(0, 1, 0, 0, 1, 0, 0,   0,  0, 0, 0, 0)); // 19 clear beats tick
    vq.push_back(mk(0, 0, 0, 1, 1, 0, 0,   0,  0, 1, 0, 0)); // 20 start, clear held
    vq.push_back(mk(0, 1, 0, 0, 1, 0, 0,   0,  1, 1, 0, 0)); // 21 no re-clear
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 0,   0,  1, 0, 0, 0)); // 22 run -> adjust
    vq.push_back(mk(0, 0, 1, 0, 1, 1, 0,   0,  0, 0, 0, 0)); // 23 clear in adjust
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 0,   0,  0, 0, 0, 0)); // 24 idle -> adjust
    vq.push_back(mk(0, 0, 1, 0, 0, 1, 0,   0,  1, 0, 0, 1)); // 25
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0,   0,  1, 0, 0, 0)); // 26 to pause

    foreach (vq[i]) begin
      rst = vq[i].rst;
      cyc(vq[i].t1, vq[i].t2, vq[i].bp, vq[i].br, vq[i].adj, vq[i].sel);
      chk_all($sformatf("vec%0d", i), int'(vq[i].emin), int'(vq[i].esec),
              vq[i].erun, vq[i].ebmin, vq[i].ebsec);
    end

    // Start and 61 seconds of counting.
    do_reset();
    cyc(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 61; i++) begin
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
    end
    chk_all("start61", 1, 1, 1, 0, 0);

    // Preset 59:58 through adjust, then wrap to 00:00 in RUN.
    do_reset();
    cyc(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 59; i++) cyc(0, 1, 0, 0, 1, 1);
    for (int i = 0; i < 58; i++) cyc(0, 1, 0, 0, 1, 0);
    chk_all("preset", 59, 58, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk_all("wrap_5959", 59, 59, 1, 0, 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk_all("wrap_0000", 0, 0, 1, 0, 0);

    // Adjust seconds wrap without carry into minutes.
    cyc(0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 7; i++) cyc(0, 1, 0, 0, 1, 1);
    for (int i = 0; i < 59; i++) cyc(0, 1, 0, 0, 1, 0);
    chk_all("adj_sec59", 7, 59, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 0);
    chk_all("adj_sec_wrap", 7, 0, 0, 0, 1);

    // Clear priority at 12:34 in RUN, then held clear does not re-clear.
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 1, 1);
    for (int i = 0; i < 34; i++) cyc(0, 1, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk_all("run_1234", 12, 34, 1, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    chk_all("clear_tick", 0, 0, 0, 0, 0);
    cyc(0, 0, 1, 1, 0, 0);
    cyc(1, 0, 0, 1, 0, 0);
    chk_all("clear_held", 0, 1, 1, 0, 0);

    // Asynchronous reset mid-RUN, checked before the next clock edge.
    #2;
    rst = 1'b1;
    #1;
    chk_all("async_mid_run", 0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc(0, 0, 0, 0, 0, 0);
    chk_all("after_async", 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
